// File: rtl/aes_ext_pkg.sv
// Shared types and constants for the AES extension block sequencer.
// The extension-select encodings must match the decoder's.
package aes_ext_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_AES_GO,
        ST_AES_WAIT,
        ST_WR,
        ST_NEXT,
        ST_DONE
    } state_t;

    localparam logic [2:0] EXT_AES_ENC = 3'd1;
    localparam logic [2:0] EXT_AES_DEC = 3'd2;

    localparam int AES_WORDS       = 4;
    localparam int AES_BLOCK_BYTES = 16;

    function automatic logic is_aes_mode(input logic [2:0] sel);
        return (sel == EXT_AES_ENC) || (sel == EXT_AES_DEC);
    endfunction

endpackage

// File: rtl/aes_block_buffer.sv
// 128-bit block register: word-indexed 32-bit write/read ports plus a full-width load.
// A full load takes priority over a word write in the same cycle.
module aes_block_buffer
    import aes_ext_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [1:0]                wr_idx,
    input  logic [31:0]               wr_data,
    input  logic                      load_en,
    input  logic [AES_WORDS*32-1:0]   load_data,
    input  logic [1:0]                rd_idx,
    output logic [31:0]               rd_data,
    output logic [AES_WORDS*32-1:0]   data
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
        end else if (load_en) begin
            data <= load_data;
        end else if (wr_en) begin
            data[{wr_idx, 5'b00000} +: 32] <= wr_data;
        end
    end

    assign rd_data = data[{rd_idx, 5'b00000} +: 32];

endmodule

// File: rtl/aes_ext_sequencer.sv
// Streams N 128-bit blocks from src through the AES core to dst over a 32-bit memory port,
// holding the core stalled via busy for the whole run.
module aes_ext_sequencer
    import aes_ext_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic              done,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_byteena,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rvalid,
    output logic              aes_start,
    output logic              aes_dec,
    output logic [127:0]      aes_din,
    input  logic [127:0]      aes_dout,
    input  logic              aes_done
);

    state_t              state;
    logic [1:0]          k;
    logic [CNT_W-1:0]    remaining;
    logic [ADDR_W-1:0]   src_q;
    logic [ADDR_W-1:0]   dst_q;
    logic                accept;
    logic                buf_wr_en;
    logic                buf_load;
    logic [1:0]          buf_rd_idx;
    logic [31:0]         buf_rd_data;

    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [1:0] idx);
        return base + ADDR_W'({idx, 2'b00});
    endfunction

    assign accept = start && is_aes_mode(mode) && (state == ST_IDLE);
    // Combinational so the issuing instruction stalls in the accept cycle itself.
    assign busy   = !rst && (accept || (state != ST_IDLE));

    assign buf_wr_en  = (state == ST_RD_WAIT) && mem_rvalid;
    assign buf_load   = (state == ST_AES_WAIT) && aes_done;
    // Write data is registered one word ahead of the word index.
    assign buf_rd_idx = k + 2'd1;

    aes_block_buffer u_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (buf_wr_en),
        .wr_idx    (k),
        .wr_data   (mem_rdata),
        .load_en   (buf_load),
        .load_data (aes_dout),
        .rd_idx    (buf_rd_idx),
        .rd_data   (buf_rd_data),
        .data      (aes_din)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            k           <= '0;
            remaining   <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            done        <= 1'b0;
            mem_re      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_byteena <= 4'b0000;
            aes_start   <= 1'b0;
            aes_dec     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        src_q     <= src_addr;
                        dst_q     <= dst_addr;
                        remaining <= count;
                        aes_dec   <= (mode == EXT_AES_DEC);
                        k         <= '0;
                        if (count == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= ST_RD_REQ;
                            mem_re   <= 1'b1;
                            mem_addr <= src_addr;
                        end
                    end
                end
                ST_RD_REQ: begin
                    if (mem_ready) begin
                        mem_re <= 1'b0;
                        state  <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (mem_rvalid) begin
                        if (k == 2'd3) begin
                            k         <= '0;
                            aes_start <= 1'b1;
                            state     <= ST_AES_GO;
                        end else begin
                            k        <= k + 2'd1;
                            mem_re   <= 1'b1;
                            mem_addr <= word_addr(src_q, k + 2'd1);
                            state    <= ST_RD_REQ;
                        end
                    end
                end
                ST_AES_GO: begin
                    aes_start <= 1'b0;
                    state     <= ST_AES_WAIT;
                end
                ST_AES_WAIT: begin
                    if (aes_done) begin
                        mem_we      <= 1'b1;
                        mem_addr    <= dst_q;
                        mem_wdata   <= aes_dout[31:0];
                        mem_byteena <= 4'b1111;
                        state       <= ST_WR;
                    end
                end
                ST_WR: begin
                    if (mem_ready) begin
                        if (k == 2'd3) begin
                            k           <= '0;
                            mem_we      <= 1'b0;
                            mem_byteena <= 4'b0000;
                            state       <= ST_NEXT;
                        end else begin
                            k         <= k + 2'd1;
                            mem_addr  <= word_addr(dst_q, k + 2'd1);
                            mem_wdata <= buf_rd_data;
                        end
                    end
                end
                ST_NEXT: begin
                    src_q     <= src_q + ADDR_W'(AES_BLOCK_BYTES);
                    dst_q     <= dst_q + ADDR_W'(AES_BLOCK_BYTES);
                    remaining <= remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        mem_re   <= 1'b1;
                        mem_addr <= src_q + ADDR_W'(AES_BLOCK_BYTES);
                        state    <= ST_RD_REQ;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_ext_sequencer.sv
// Bench for aes_ext_sequencer: memory and AES core models, expected-queue scoreboard,
// directed runs for single/multi block, count=0, bad mode, wrap, backpressure and reset.
module tb_aes_ext_sequencer;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2:0]    mode;
    logic [31:0]   src_addr;
    logic [31:0]   dst_addr;
    logic [11:0]   count;
    logic          busy;
    logic          done;
    logic          mem_re;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_byteena;
    logic          mem_ready;
    logic [31:0]   mem_rdata;
    logic          mem_rvalid;
    logic          aes_start;
    logic          aes_dec;
    logic [127:0]  aes_din;
    logic [127:0]  aes_dout;
    logic          aes_done;

    aes_ext_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mode        (mode),
        .src_addr    (src_addr),
        .dst_addr    (dst_addr),
        .count       (count),
        .busy        (busy),
        .done        (done),
        .mem_re      (mem_re),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_byteena (mem_byteena),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .mem_rvalid  (mem_rvalid),
        .aes_start   (aes_start),
        .aes_dec     (aes_dec),
        .aes_din     (aes_din),
        .aes_dout    (aes_dout),
        .aes_done    (aes_done)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [31:0]  rd_q[$];
    logic [63:0]  wr_q[$];
    logic [127:0] din_q[$];
    int  n_checks = 0;
    int  n_err    = 0;
    int  n_reads  = 0;
    int  n_writes = 0;
    int  n_aes_starts = 0;
    bit  bp = 1'b0;
    int  aes_lat = 3;
    logic exp_dec = 1'b0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    function automatic logic [127:0] core(input logic [127:0] din, input logic dec);
        logic [127:0] key;
        key = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
        if (dec) return {din[31:0], din[127:32]} ^ ~key;
        return {din[95:0], din[127:96]} ^ key;
    endfunction

    task automatic push_job(input logic [31:0] s, input logic [31:0] d,
                            input logic [11:0] n, input logic dec);
        logic [127:0] din;
        logic [127:0] dout;
        logic [31:0]  a;
        for (int b = 0; b < int'(n); b++) begin
            for (int i = 0; i < 4; i++) begin
                a = s + 32'(16 * b + 4 * i);
                rd_q.push_back(a);
                din[32*i +: 32] = mem_word(a);
            end
            din_q.push_back(din);
            dout = core(din, dec);
            for (int i = 0; i < 4; i++)
                wr_q.push_back({d + 32'(16 * b + 4 * i), dout[32*i +: 32]});
        end
    endtask

    // ---------------- memory model ----------------
    bit          rd_pending = 1'b0;
    int          rd_delay   = 0;
    logic [31:0] rd_addr    = '0;
    bit          held       = 1'b0;
    logic [65:0] held_val   = '0;
    logic [63:0] wexp;

    always @(negedge clk) begin
        mem_rvalid = 1'b0;
        if (rst) begin
            rd_pending = 1'b0;
            held       = 1'b0;
            mem_ready  = 1'b0;
            rd_q.delete();
            wr_q.delete();
        end else begin
            if (rd_pending) begin
                if (rd_delay == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem_word(rd_addr);
                    rd_pending = 1'b0;
                end else begin
                    rd_delay--;
                end
            end
            if (mem_re || mem_we) begin
                check("re_we_exclusive", mem_re & mem_we, 1'b0);
                if (held)
                    check("req_stable", {mem_re, mem_we, mem_addr, mem_wdata}, held_val);
                if (mem_re)
                    check("one_outstanding", rd_pending, 1'b0);
                mem_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (mem_ready) begin
                    held = 1'b0;
                    if (mem_re) begin
                        n_reads++;
                        check("rd_expected", rd_q.size() != 0, 1'b1);
                        if (rd_q.size() != 0) check("rd_addr", mem_addr, rd_q.pop_front());
                        rd_pending = 1'b1;
                        rd_delay   = bp ? int'($urandom_range(0, 4)) : 0;
                        rd_addr    = mem_addr;
                    end else begin
                        n_writes++;
                        check("wr_byteena", mem_byteena, 4'b1111);
                        check("wr_expected", wr_q.size() != 0, 1'b1);
                        if (wr_q.size() != 0) begin
                            wexp = wr_q.pop_front();
                            check("wr_addr", mem_addr, wexp[63:32]);
                            check("wr_data", mem_wdata, wexp[31:0]);
                        end
                    end
                end else begin
                    held     = 1'b1;
                    held_val = {mem_re, mem_we, mem_addr, mem_wdata};
                end
            end else begin
                held      = 1'b0;
                mem_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    // ---------------- AES core model ----------------
    int           aes_timer = 0;
    logic [127:0] cap_din   = '0;
    logic         cap_dec   = 1'b0;

    always @(negedge clk) begin
        aes_done = 1'b0;
        if (aes_timer > 0) begin
            aes_timer--;
            if (aes_timer == 0) begin
                aes_done = 1'b1;
                aes_dout = core(cap_din, cap_dec);
            end
        end
        if (rst) begin
            din_q.delete();
        end else if (aes_start) begin
            n_aes_starts++;
            check("aes_dec", aes_dec, exp_dec);
            check("aes_din_expected", din_q.size() != 0, 1'b1);
            if (din_q.size() != 0) check("aes_din", aes_din, din_q.pop_front());
            cap_din   = aes_din;
            cap_dec   = aes_dec;
            aes_timer = aes_lat;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_job(input logic [2:0] m, input logic [31:0] s, input logic [31:0] d,
                           input logic [11:0] n, input bit intrude, input int exp_cycle);
        int cyc;
        bit seen;
        int starts0;
        starts0 = n_aes_starts;
        exp_dec = (m == 3'd2);
        push_job(s, d, n, m == 3'd2);
        start = 1'b1; mode = m; src_addr = s; dst_addr = d; count = n;
        #1 check("busy_on_accept", busy, 1'b1);
        @(negedge clk);
        start = 1'b0; mode = 3'd0;
        cyc = 1;
        seen = 1'b0;
        while (!seen && cyc < 3000) begin
            if (intrude && cyc == 5) begin
                start = 1'b1; mode = 3'd1; src_addr = 32'hDEAD_0000;
                dst_addr = 32'hBEEF_0000; count = 12'd7;
            end else if (intrude && cyc == 6) begin
                start = 1'b0; mode = 3'd0;
            end
            #1;
            if (done) begin
                seen = 1'b1;
            end else begin
                check("busy_during_run", busy, 1'b1);
                @(negedge clk);
                cyc++;
            end
        end
        check("done_seen", seen, 1'b1);
        if (exp_cycle >= 0) check("done_cycle", cyc, exp_cycle);
        check("aes_start_count", n_aes_starts - starts0, int'(n));
        @(negedge clk);
        #1;
        check("busy_after_done", busy, 1'b0);
        check("done_one_cycle", done, 1'b0);
        check("rd_q_drained", rd_q.size(), 0);
        check("wr_q_drained", wr_q.size(), 0);
        check("din_q_drained", din_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, {busy, done, mem_re, mem_we, aes_start, aes_dec}, 6'b0);
        check({tag, "_mem"}, {mem_addr, mem_wdata, mem_byteena}, 68'h0);
        check({tag, "_din"}, aes_din, 128'h0);
    endtask

    // ---------------- directed sequence ----------------
    int traffic0;
    int guard;

    initial begin
        rst = 1'b1; start = 1'b0; mode = 3'd0; src_addr = '0; dst_addr = '0; count = '0;
        mem_ready = 1'b0; mem_rdata = '0; mem_rvalid = 1'b0; aes_dout = '0; aes_done = 1'b0;
        repeat (3) @(negedge clk);
        #1 check_reset_outputs("reset_init");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // single block, encrypt
        run_job(3'd1, 32'h100, 32'h200, 12'd1, 1'b0, 18);

        // three blocks, decrypt, with an ignored start while busy
        run_job(3'd2, 32'h2000, 32'h2800, 12'd3, 1'b1, 3 * 17 + 1);

        // count = 0: done at cycle 1 without memory traffic
        traffic0 = n_reads + n_writes;
        run_job(3'd1, 32'h40, 32'h80, 12'd0, 1'b0, 1);
        check("count0_no_traffic", n_reads + n_writes, traffic0);

        // unsupported extension select is ignored
        traffic0 = n_reads + n_writes;
        start = 1'b1; mode = 3'd3; src_addr = 32'h300; dst_addr = 32'h380; count = 12'd1;
        #1 check("bad_mode_busy", busy, 1'b0);
        @(negedge clk);
        start = 1'b0; mode = 3'd0;
        for (int i = 0; i < 20; i++) begin
            #1 check("bad_mode_idle", {busy, done}, 2'b00);
            @(negedge clk);
        end
        check("bad_mode_no_traffic", n_reads + n_writes, traffic0);

        // address wrap across 2^32
        run_job(3'd1, 32'hFFFF_FFF8, 32'h600, 12'd1, 1'b0, 18);

        // backpressure and variable core latency
        bp = 1'b1;
        aes_lat = int'($urandom_range(1, 6));
        run_job(3'd1, 32'h1000, 32'h3000, 12'd4, 1'b0, -1);
        aes_lat = int'($urandom_range(1, 6));
        run_job(3'd2, 32'h7FF0, 32'h7FF8, 12'd2, 1'b0, -1);
        bp = 1'b0;
        @(negedge clk);

        // reset while waiting on the core
        aes_lat = 8;
        exp_dec = 1'b0;
        push_job(32'h400, 32'h500, 12'd2, 1'b0);
        start = 1'b1; mode = 3'd1; src_addr = 32'h400; dst_addr = 32'h500; count = 12'd2;
        @(negedge clk);
        start = 1'b0; mode = 3'd0;
        guard = 0;
        while (!aes_start && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("reset_reached_aes", aes_start, 1'b1);
        repeat (2) @(negedge clk);
        traffic0 = n_writes;
        rst = 1'b1;
        #1 check_reset_outputs("reset_async");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            #1 check("post_reset_idle", {busy, done, mem_re, mem_we}, 4'b0000);
            @(negedge clk);
        end
        check("late_aes_done_no_write", n_writes, traffic0);

        // normal run after reset
        aes_lat = 3;
        run_job(3'd1, 32'h900, 32'hA00, 12'd1, 1'b0, 18);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/aes_ext_sequencer.md
# aes_ext_sequencer

Multi-block sequencer for the AES-128 extension instructions (extension select 1 = encrypt, 2 = decrypt). The decoder issues one start with src (rs1), dst (rd) and a 12-bit block count (imm). The block then streams each 128-bit block through the 32-bit data memory port and the AES core: read 4 words, run the core, write 4 words. It stalls the core via `busy` until the whole run completes.

## Interface
- `ADDR_W`, 32, memory address / data-word width
- `CNT_W`, 12, block-count width
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  request from decode (exalu enabled, AES opcode)
- `mode`  in  3  extension select; only 1 (enc) and 2 (dec) are accepted
- `src_addr`  in  ADDR_W  first source byte address
- `dst_addr`  in  ADDR_W  first destination byte address
- `count`  in  CNT_W  number of 128-bit blocks
- `busy`  out  1  core stall; the core holds pcWE low while this is high
- `done`  out  1  one-cycle completion pulse
- `mem_re`, `mem_we`  out  1  read / write request, held until `mem_ready`
- `mem_addr`  out  ADDR_W  word address of the current request
- `mem_wdata`  out  32  write data
- `mem_byteena`  out  4  4'b1111 during writes, else 4'b0000
- `mem_ready`  in  1  request accepted this cycle
- `mem_rdata`  in  32  read data
- `mem_rvalid`  in  1  read data valid; never in the acceptance cycle
- `aes_start`  out  1  one-cycle core start
- `aes_dec`  out  1  0 = encrypt, 1 = decrypt
- `aes_din`  out  128  block buffer
- `aes_dout`  in  128  core result
- `aes_done`  in  1  core result valid

## Operation
- **States:** IDLE, RD_REQ, RD_WAIT, AES_GO, AES_WAIT, WR, NEXT, DONE. A 2-bit word index `k` and a CNT_W remaining counter are kept alongside the state.
- **IDLE:**
  - A start is accepted when `start` is high and `mode` is 1 or 2. On accept, latch the addresses, count and `aes_dec` = (`mode` == 2).
  - After accept, go to RD_REQ, or to DONE if `count` == 0.
  - A start with any other `mode` is ignored. A start in any non-IDLE state is ignored.
- **RD_REQ:**
  - Drive `mem_re` = 1 and `mem_addr` = src + 4k.
  - On `mem_ready`, go to RD_WAIT.
- **RD_WAIT:**
  - On `mem_rvalid`, write buffer word k, i.e. bits [32k+31:32k] (word 0 = lowest address = LSBs).
  - If k = 3, set k = 0 and go to AES_GO; otherwise k++ and return to RD_REQ.
- **AES_GO:** `aes_start` = 1 for exactly one cycle, then AES_WAIT.
- **AES_WAIT:** on `aes_done`, load `aes_dout` into the buffer, then go to WR.
- **WR:**
  - Drive `mem_we` = 1, `mem_addr` = dst + 4k, `mem_wdata` = buffer word k, `mem_byteena` = 4'b1111.
  - On `mem_ready`: if k = 3, set k = 0 and go to NEXT; otherwise k++.
- **NEXT:**
  - Update: src += 16, dst += 16, remaining--.
  - If remaining becomes 0, go to DONE; otherwise go to RD_REQ.
- **DONE:** `done` = 1 for one cycle, then IDLE.
- **Arithmetic:** addresses wrap modulo 2^ADDR_W. No alignment checking; the low 2 address bits pass through as given.
- **Overlap:** src/dst overlap is allowed. Each block is fully read before it is written.
- **Reset mid-run:** return to IDLE immediately and drop every output to its reset value. In-flight memory and AES operations are abandoned; any late `mem_rvalid` or `aes_done` seen in IDLE is ignored.

## Timing
- **Reset values:** `busy`, `done`, `mem_re`, `mem_we`, `aes_start`, `aes_dec` = 0; `mem_addr`, `mem_wdata`, `aes_din` = 0; `mem_byteena` = 0.
- **`busy`:** `busy` = accepted-start | (state != IDLE). It is combinationally high in the accept cycle so the issuing instruction stalls at once. It is low in the cycle after DONE.
- **Cycle budget (start accepted at cycle 0, ideal memory: `mem_ready` always 1, `mem_rvalid` one cycle after accept, `aes_done` L ≥ 1 cycles after `aes_start`):**
  - Per block: 8 read cycles + 1 (AES_GO) + L (AES_WAIT) + 4 write cycles + 1 (NEXT) = 14 + L.
  - First RD_REQ is at cycle 1.
  - `done` is at cycle N·(14+L) + 1.
  - With `count` = 0, `done` is at cycle 1 with no memory traffic.
- **Handshake rules:**
  - `mem_re` and `mem_we` are never high together.
  - Address and data stay stable while a request is held.
  - At most one read is outstanding.

## Structure
- Package `aes_ext_pkg` holds:
  - the state enum;
  - `EXT_AES_ENC` = 3'd1 and `EXT_AES_DEC` = 3'd2, shared with the decoder's extension-select encoding;
  - `AES_WORDS` = 4;
  - `AES_BLOCK_BYTES` = 16.
- Sub-module `aes_block_buffer`: a 128-bit register with a word-indexed 32-bit write port, a word-indexed read port and a full 128-bit load/read.
- The FSM and counters stay in `aes_ext_sequencer`.

## Test plan
- **Single block:** mode=1, src=0x100, dst=0x200, count=1, ideal memory, L=3. Expect reads of 0x100, 0x104, 0x108, 0x10C, then `aes_dec`=0, then writes of 0x200–0x20C with the core output words, and `done` at cycle 18.
- **Multi-block:** mode=2, count=3. Expect `aes_dec`=1, three AES starts, the src/dst pair stepping by 16 each block, and `done` at cycle 3(14+L)+1 with `busy` high throughout.
- **count=0 and bad mode:** count=0 gives `done` at cycle 1 with no `mem_re`/`mem_we`. A start with mode=3 produces no `busy` and no `done`. A start while busy is ignored: the counts and addresses of the first run are unchanged.
- **Backpressure:**
  - Random `mem_ready` stalls and rvalid delays of 1–5 cycles.
  - The request is held stable until accepted, there is never more than one read outstanding, and the written data matches the model.
- **Wrap:** src=0xFFFF_FFF8, count=1. Read addresses are 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0, 0x4.
- **Reset mid-AES_WAIT:**
  - All outputs return to their reset values asynchronously.
  - A late `aes_done` after reset causes no write.
  - A new start then completes normally.
